// File: rtl/answer_gen_ctrl.sv
// Answer generator sequencer: steps the LCG, rejects duplicate draws and writes
// DIGITS distinct values in 1..RANGE, then holds the packed answer.
module answer_gen_ctrl #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned VAL_W     = 4,
   parameter int unsigned RANGE     = 8,
   parameter int unsigned MAX_TRIES = 64
) (
   input  logic                        clk50M,
   input  logic                        rst,
   input  logic                        change_answer,
   input  logic [31:0]                 rand_i,
   output logic                        rand_step,
   output logic                        busy,
   output logic                        answer_valid,
   output logic [DIGITS*VAL_W-1:0]     answer,
   output logic                        wr_en,
   output logic [$clog2(DIGITS)-1:0]   wr_addr,
   output logic [VAL_W-1:0]            wr_data,
   output logic                        error
);

   localparam int unsigned AW = $clog2(DIGITS);
   localparam int unsigned LW = $clog2(RANGE);
   localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   typedef enum logic [2:0] {IDLE, STEP, CHECK, WRITE, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      req_q;
   logic [AW-1:0]             idx_q, idx_d;
   logic [TW-1:0]             tries_q, tries_d;
   logic [DIGITS*VAL_W-1:0]   answer_q, answer_d;
   logic                      error_q, error_d;
   logic [AW-1:0]             wr_addr_q, wr_addr_d;
   logic [VAL_W-1:0]          wr_data_q, wr_data_d;
   logic                      rand_step_q, busy_q, wr_en_q, valid_q;
   logic [VAL_W-1:0]          cand_c;
   logic                      dup_c;
   logic                      rand_hi_unused;

   assign rand_hi_unused = ^rand_i[31:LW];

   always_comb begin
      cand_c = VAL_W'(rand_i[LW-1:0]) + VAL_W'(1);
      dup_c  = 1'b0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
         if ((j < 32'(idx_q)) && (answer_q[j*VAL_W +: VAL_W] == cand_c)) dup_c = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tries_d   = tries_q;
      answer_d  = answer_q;
      error_d   = error_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (req_q) begin
               state_d  = STEP;
               idx_d    = '0;
               tries_d  = '0;
               answer_d = '0;
               error_d  = 1'b0;
            end
         end
         STEP: state_d = CHECK;
         CHECK: begin
            if (!dup_c) begin
               state_d   = WRITE;
               wr_addr_d = idx_q;
               wr_data_d = cand_c;
               answer_d[idx_q*VAL_W +: VAL_W] = cand_c;
            end else if (tries_q != TW'(MAX_TRIES - 1)) begin
               state_d = STEP;
               tries_d = tries_q + TW'(1);
            end else begin
               state_d  = IDLE;
               error_d  = 1'b1;
               answer_d = '0;
            end
         end
         WRITE: begin
            tries_d = '0;
            if (idx_q == AW'(DIGITS - 1)) begin
               state_d = DONE;
            end else begin
               state_d = STEP;
               idx_d   = idx_q + AW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The request is registered ahead of the FSM, so answer_valid rises
   // 3*DIGITS+1 edges after the edge that first samples change_answer high.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         idx_q       <= '0;
         tries_q     <= '0;
         answer_q    <= '0;
         error_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rand_step_q <= 1'b0;
         busy_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= change_answer;
         idx_q       <= idx_d;
         tries_q     <= tries_d;
         answer_q    <= answer_d;
         error_q     <= error_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rand_step_q <= (state_d == STEP);
         busy_q      <= (state_d == STEP) || (state_d == CHECK) || (state_d == WRITE);
         wr_en_q     <= (state_d == WRITE);
         valid_q     <= (state_d == DONE);
      end
   end

   assign rand_step    = rand_step_q;
   assign busy         = busy_q;
   assign answer_valid = valid_q;
   assign answer       = answer_q;
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign error        = error_q;

endmodule

// File: tb/tb_answer_gen_ctrl.sv
// Scoreboard bench for answer_gen_ctrl: a draw-level reference model predicts
// digit writes, final answer/latency or abort; a negedge monitor checks them.
module tb_answer_gen_ctrl;

   localparam int unsigned DIGITS    = 4;
   localparam int unsigned VAL_W     = 4;
   localparam int unsigned RANGE     = 8;
   localparam int unsigned MAX_TRIES = 8;
   localparam int unsigned AW        = $clog2(DIGITS);

   logic                      clk50M = 1'b0;
   logic                      rst = 1'b1;
   logic                      change_answer = 1'b0;
   logic [31:0]               rand_i = '0;
   logic                      rand_step, busy, answer_valid, wr_en, error;
   logic [DIGITS*VAL_W-1:0]   answer;
   logic [AW-1:0]             wr_addr;
   logic [VAL_W-1:0]          wr_data;

   answer_gen_ctrl #(
      .DIGITS   (DIGITS),
      .VAL_W    (VAL_W),
      .RANGE    (RANGE),
      .MAX_TRIES(MAX_TRIES)
   ) dut (
      .clk50M       (clk50M),
      .rst          (rst),
      .change_answer(change_answer),
      .rand_i       (rand_i),
      .rand_step    (rand_step),
      .busy         (busy),
      .answer_valid (answer_valid),
      .answer       (answer),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .error        (error)
   );

   always #5 clk50M = ~clk50M;

   typedef enum int {K_WR, K_DONE, K_ERR} kind_t;
   typedef struct {
      kind_t                   kind;
      int                      addr;
      int                      data;
      logic [DIGITS*VAL_W-1:0] ans;
      int                      lat;
      int                      steps;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] feed_q[$];
   int          plan_q[$];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   int          req_edge = 0;
   int          steps_seen = 0;
   bit          step_pend = 0;
   bit          prev_valid = 0;
   bit          prev_error = 0;
   exp_t        mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model: plays the draw rules directly on a list of values.
   task automatic run_model();
      int   digits[$];
      int   tries;
      int   rejects;
      int   steps;
      int   v;
      bit   dup;
      bit   fin;
      exp_t e;
      tries = 0; rejects = 0; steps = 0; fin = 0;
      while (!fin) begin
         v = (plan_q.size() > 0) ? plan_q.pop_front() : int'($urandom_range(RANGE - 1, 0));
         feed_q.push_back(($urandom & ~32'(RANGE - 1)) | 32'(v));
         steps++;
         dup = 0;
         foreach (digits[k]) if (digits[k] == v + 1) dup = 1;
         e.addr = 0; e.data = 0; e.ans = '0; e.lat = 0; e.steps = steps;
         if (dup) begin
            tries++;
            rejects++;
            if (tries == int'(MAX_TRIES)) begin
               e.kind = K_ERR;
               exp_q.push_back(e);
               fin = 1;
            end
         end else begin
            e.kind = K_WR;
            e.addr = digits.size();
            e.data = v + 1;
            exp_q.push_back(e);
            digits.push_back(v + 1);
            tries = 0;
            if (digits.size() == int'(DIGITS)) begin
               e.kind = K_DONE;
               foreach (digits[k]) e.ans[k*VAL_W +: VAL_W] = VAL_W'(digits[k]);
               e.lat = 3 * int'(DIGITS) + 1 + 2 * rejects;
               exp_q.push_back(e);
               fin = 1;
            end
         end
      end
   endtask

   always @(posedge clk50M) edge_cnt++;

   // PRNG stand-in: next value appears just after the edge that ends a rand_step cycle.
   always @(posedge clk50M) begin
      if (step_pend) begin
         step_pend = 0;
         #1;
         if (feed_q.size() > 0) rand_i = feed_q.pop_front();
         else rand_i = $urandom;
      end
   end

   always @(negedge clk50M) begin
      if (rst) begin
         prev_valid = 0;
         prev_error = 0;
         step_pend  = 0;
      end else begin
         step_pend = rand_step;
         if (rand_step) steps_seen++;
         if (wr_en) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_WR) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
               chk("wr_data", 64'(wr_data), 64'(mon_e.data));
            end
         end
         if (answer_valid && !prev_valid) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_DONE) begin
               checks++; errors++;
               $display("FAIL unexpected_valid: got answer 0x%0h, expected no completion", answer);
            end else begin
               mon_e = exp_q.pop_front();
               chk("answer", 64'(answer), 64'(mon_e.ans));
               chk("valid_latency", 64'(edge_cnt - req_edge), 64'(mon_e.lat));
               chk("draw_count", 64'(steps_seen), 64'(mon_e.steps));
            end
         end
         if (error && !prev_error) begin
            if (exp_q.size() == 0 || exp_q[0].kind != K_ERR) begin
               checks++; errors++;
               $display("FAIL unexpected_error: got error 1, expected no abort");
            end else begin
               mon_e = exp_q.pop_front();
               chk("abort_answer", 64'(answer), 64'(0));
               chk("abort_busy", 64'(busy), 64'(0));
               chk("abort_draw_count", 64'(steps_seen), 64'(mon_e.steps));
            end
         end
         chk("valid_error_exclusive", 64'(answer_valid & error), 64'(0));
         prev_valid = answer_valid;
         prev_error = error;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk50M);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL completion_timeout: got %0d events pending after %0d cycles, expected 0", exp_q.size(), n);
         exp_q.delete();
      end
      @(posedge clk50M); #1;
   endtask

   task automatic request(input bit wait_done);
      run_model();
      @(posedge clk50M); #1;
      change_answer = 1'b1;
      steps_seen    = 0;
      req_edge      = edge_cnt + 1;
      @(posedge clk50M); #1;
      change_answer = 1'b0;
      @(posedge clk50M);
      @(negedge clk50M);
      chk("accept_clears_valid", 64'(answer_valid), 64'(0));
      chk("accept_clears_error", 64'(error), 64'(0));
      chk("busy_after_accept", 64'(busy), 64'(1));
      if (wait_done) wait_idle();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rand_step"}, 64'(rand_step), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_valid"}, 64'(answer_valid), 64'(0));
      chk({tag, "_answer"}, 64'(answer), 64'(0));
      chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
      chk({tag, "_error"}, 64'(error), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected end of stimulus");
      $fatal(1);
   end

   initial begin
      #12;
      chk_all_zero("reset");
      @(negedge clk50M);
      rst = 1'b0;

      // T1: idle with no request
      steps_seen = 0;
      repeat (100) @(posedge clk50M);
      #1;
      chk("idle_no_steps", 64'(steps_seen), 64'(0));
      chk_all_zero("idle");

      // T2: four clean draws
      plan_q = '{3, 5, 0, 6};
      request(1);
      chk("t2_answer", 64'(answer), 64'(16'h7164));
      chk("t2_valid_held", 64'(answer_valid), 64'(1));

      // T3: one rejected draw
      plan_q = '{3, 3, 5, 0, 6};
      request(1);
      chk("t3_answer", 64'(answer), 64'(16'h7164));
      chk("t3_steps", 64'(steps_seen), 64'(5));

      // T4: retry limit reached on digit 1
      plan_q = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
      request(1);
      repeat (5) @(posedge clk50M);
      #1;
      chk("t4_error", 64'(error), 64'(1));
      chk("t4_answer", 64'(answer), 64'(0));
      chk("t4_busy", 64'(busy), 64'(0));
      chk("t4_steps", 64'(steps_seen), 64'(MAX_TRIES + 1));

      // T5: request pulse while busy is ignored; re-request from DONE
      request(0);
      repeat (4) @(posedge clk50M);
      #1;
      change_answer = 1'b1;
      @(posedge clk50M); #1;
      change_answer = 1'b0;
      wait_idle();
      repeat (4) @(posedge clk50M);
      #1;
      chk("t5_valid_in_done", 64'(answer_valid), 64'(1));
      chk("t5_busy_in_done", 64'(busy), 64'(0));
      request(1);

      // T6: asynchronous reset while in CHECK
      request(0);
      @(posedge clk50M);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("t6_async_reset");
      exp_q.delete();
      feed_q.delete();
      plan_q.delete();
      repeat (2) @(posedge clk50M);
      @(negedge clk50M);
      rst = 1'b0;
      plan_q = '{3, 5, 0, 6};
      request(1);
      chk("t6_answer", 64'(answer), 64'(16'h7164));

      // Randomized requests
      repeat (25) request(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
